// File: rtl/xgmii_link_fault.sv
// XGMII link fault signalling: detects local/remote fault sequence columns on RX and overrides TX.
// Optional fault-entry statistics counter enabled by defining LINK_FAULT_STATS_EN.
module xgmii_link_fault #(
  parameter int C_SEQ_THRESH = 4,
  parameter int C_WINDOW     = 64
) (
  input  logic        clk156,
  input  logic        reset,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [63:0] mac_txd,
  input  logic [7:0]  mac_txc,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        local_fault,
  output logic        remote_fault,
  output logic        link_ok
`ifdef LINK_FAULT_STATS_EN
  ,
  output logic [15:0] fault_cnt
`endif
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam int              WIN_W    = $clog2(C_WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(C_WINDOW - 1);
  localparam logic [3:0]      THRESH   = 4'(C_SEQ_THRESH);

  localparam logic [63:0] TX_RF_D   = 64'h0200009C_0200009C;
  localparam logic [7:0]  TX_RF_C   = 8'h11;
  localparam logic [63:0] TX_IDLE_D = 64'h07070707_07070707;
  localparam logic [7:0]  TX_IDLE_C = 8'hFF;

  // Returns {is_sequence, is_remote} for one 32-bit column.
  function automatic logic [1:0] col_decode(input logic [31:0] d, input logic [3:0] c);
    col_decode = 2'b00;
    if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
      if (d[31:24] == 8'h01)      col_decode = 2'b10;
      else if (d[31:24] == 8'h02) col_decode = 2'b11;
    end
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       seq_cnt_q, seq_cnt_d;
  logic             last_type_q, last_type_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             local_q, local_d, remote_q, remote_d, link_ok_q;
  logic [63:0]      txd_q;
  logic [7:0]       txc_q;

  logic [1:0] col0, col1, n;
  logic       wtype;
  logic [3:0] sum;
  logic [2:0] sum_sat;
  logic       win_last;

  always_comb begin
    col0  = col_decode(xgmii_rxd[31:0],  xgmii_rxc[3:0]);
    col1  = col_decode(xgmii_rxd[63:32], xgmii_rxc[7:4]);
    n     = 2'd0;
    wtype = 1'b0;
    if (col0[1] && col1[1]) begin
      // Disagreeing columns collapse to a single column-1 sequence.
      n     = (col0[0] == col1[0]) ? 2'd2 : 2'd1;
      wtype = col1[0];
    end else if (col0[1]) begin
      n     = 2'd1;
      wtype = col0[0];
    end else if (col1[1]) begin
      n     = 2'd1;
      wtype = col1[0];
    end
    sum      = {1'b0, seq_cnt_q} + {2'b00, n};
    sum_sat  = (sum > 4'd7) ? 3'd7 : sum[2:0];
    win_last = (win_cnt_q == WIN_LAST);
  end

  always_comb begin
    state_d     = state_q;
    seq_cnt_d   = seq_cnt_q;
    last_type_d = last_type_q;
    win_cnt_d   = win_cnt_q;
    local_d     = local_q;
    remote_d    = remote_q;
    case (state_q)
      S_INIT: begin
        if (n != 2'd0) begin
          last_type_d = wtype;
          seq_cnt_d   = {1'b0, n};
          win_cnt_d   = '0;
          state_d     = S_COUNT;
        end
      end
      S_COUNT: begin
        if (n == 2'd0) begin
          if (win_last) begin
            state_d   = S_INIT;
            seq_cnt_d = 3'd0;
            win_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end else if (wtype == last_type_q) begin
          seq_cnt_d = sum_sat;
          win_cnt_d = '0;
          if ({1'b0, sum_sat} >= THRESH) begin
            state_d  = S_FAULT;
            local_d  = !last_type_q;
            remote_d = last_type_q;
          end
        end else begin
          last_type_d = wtype;
          seq_cnt_d   = {1'b0, n};
          win_cnt_d   = '0;
        end
      end
      S_FAULT: begin
        if (n == 2'd0) begin
          if (win_last) begin
            state_d   = S_INIT;
            seq_cnt_d = 3'd0;
            win_cnt_d = '0;
            local_d   = 1'b0;
            remote_d  = 1'b0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end else if (wtype == last_type_q) begin
          win_cnt_d = '0;
        end else begin
          state_d     = S_COUNT;
          last_type_d = wtype;
          seq_cnt_d   = {1'b0, n};
          win_cnt_d   = '0;
          local_d     = 1'b0;
          remote_d    = 1'b0;
        end
      end
      default: begin
        state_d   = S_INIT;
        seq_cnt_d = 3'd0;
        win_cnt_d = '0;
        local_d   = 1'b0;
        remote_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      state_q     <= S_INIT;
      seq_cnt_q   <= 3'd0;
      last_type_q <= 1'b0;
      win_cnt_q   <= '0;
      local_q     <= 1'b0;
      remote_q    <= 1'b0;
      link_ok_q   <= 1'b0;
      txd_q       <= TX_IDLE_D;
      txc_q       <= TX_IDLE_C;
    end else begin
      state_q     <= state_d;
      seq_cnt_q   <= seq_cnt_d;
      last_type_q <= last_type_d;
      win_cnt_q   <= win_cnt_d;
      local_q     <= local_d;
      remote_q    <= remote_d;
      link_ok_q   <= !(local_d | remote_d);
      // TX override follows the flags being loaded on this same edge.
      if (local_d) begin
        txd_q <= TX_RF_D;
        txc_q <= TX_RF_C;
      end else if (remote_d) begin
        txd_q <= TX_IDLE_D;
        txc_q <= TX_IDLE_C;
      end else begin
        txd_q <= mac_txd;
        txc_q <= mac_txc;
      end
    end
  end

`ifdef LINK_FAULT_STATS_EN
  logic [15:0] fault_cnt_q;
  logic        enter_fault;
  assign enter_fault = (state_q == S_COUNT) && (state_d == S_FAULT);

  always_ff @(posedge clk156) begin
    if (reset)                                     fault_cnt_q <= 16'd0;
    else if (enter_fault && fault_cnt_q != 16'hFFFF) fault_cnt_q <= fault_cnt_q + 16'd1;
  end
  assign fault_cnt = fault_cnt_q;
`endif

  assign xgmii_txd    = txd_q;
  assign xgmii_txc    = txc_q;
  assign local_fault  = local_q;
  assign remote_fault = remote_q;
  assign link_ok      = link_ok_q;

endmodule

// File: tb/tb_xgmii_link_fault.sv
// Self-checking bench for xgmii_link_fault: directed scenarios plus randomized traffic against a word-level model.
// Define LINK_FAULT_STATS_EN for both RTL and bench to exercise the fault counter.
module tb_xgmii_link_fault;
  localparam int TH  = 4;
  localparam int WIN = 64;

  localparam logic [63:0] W_LOC0 = {32'h07070707, 32'h0100009C};
  localparam logic [63:0] W_REM0 = {32'h07070707, 32'h0200009C};
  localparam logic [7:0]  C_ONE0 = 8'hF1;
  localparam logic [63:0] W_REM2 = 64'h0200009C_0200009C;
  localparam logic [63:0] W_LOC2 = 64'h0100009C_0100009C;
  localparam logic [7:0]  C_TWO  = 8'h11;
  localparam logic [63:0] W_IDLE = 64'h07070707_07070707;
  localparam logic [7:0]  C_IDLE = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rxd, mtxd;
  logic [7:0]  rxc, mtxc;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        local_fault, remote_fault, link_ok;
`ifdef LINK_FAULT_STATS_EN
  logic [15:0] fault_cnt;
`endif

  xgmii_link_fault #(.C_SEQ_THRESH(TH), .C_WINDOW(WIN)) dut (
    .clk156(clk), .reset(rst),
    .xgmii_rxd(rxd), .xgmii_rxc(rxc),
    .mac_txd(mtxd), .mac_txc(mtxc),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc),
    .local_fault(local_fault), .remote_fault(remote_fault), .link_ok(link_ok)
`ifdef LINK_FAULT_STATS_EN
    , .fault_cnt(fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: m_kind is the active fault (0 none, 1 local, 2 remote); m_run counts sequences of m_last.
  int          m_kind, m_run, m_quiet, m_last, m_cnt;
  logic        m_link;
  logic [63:0] m_txd;
  logic [7:0]  m_txc;

  wire [74:0] act = {local_fault, remote_fault, link_ok, xgmii_txd, xgmii_txc};

  function automatic logic [74:0] exp_vec();
    return {m_kind == 1, m_kind == 2, m_link, m_txd, m_txc};
  endfunction

  function automatic int col_kind(input logic [31:0] d, input logic [3:0] c);
    if (c == 4'h1 && d == 32'h0100009C) return 1;
    if (c == 4'h1 && d == 32'h0200009C) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_kind = 0; m_run = 0; m_quiet = 0; m_last = 0; m_cnt = 0;
    m_link = 1'b0; m_txd = W_IDLE; m_txc = C_IDLE;
  endtask

  task automatic model_word(input logic [63:0] d, input logic [7:0] c,
                            input logic [63:0] md, input logic [7:0] mc);
    int k0, k1, n, t;
    k0 = col_kind(d[31:0], c[3:0]);
    k1 = col_kind(d[63:32], c[7:4]);
    n = (k0 != 0) + (k1 != 0);
    t = (k1 != 0) ? k1 : k0;
    if (k0 != 0 && k1 != 0 && k0 != k1) n = 1;
    if (n == 0) begin
      if (m_kind != 0 || m_run > 0) begin
        m_quiet++;
        if (m_quiet >= WIN) begin m_kind = 0; m_run = 0; m_quiet = 0; end
      end
    end else if (m_kind != 0) begin
      m_quiet = 0;
      if (t != m_kind) begin m_kind = 0; m_last = t; m_run = n; end
    end else if (m_run > 0 && t == m_last) begin
      m_run = (m_run + n > 7) ? 7 : m_run + n;
      m_quiet = 0;
      if (m_run >= TH) begin
        m_kind = t;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      m_last = t; m_run = n; m_quiet = 0;
    end
    m_link = (m_kind == 0);
    if (m_kind == 1)      begin m_txd = W_REM2; m_txc = C_TWO;  end
    else if (m_kind == 2) begin m_txd = W_IDLE; m_txc = C_IDLE; end
    else                  begin m_txd = md;     m_txc = mc;     end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    rst = 1'b0; rxd = d; rxc = c;
    mtxd = {$urandom, $urandom}; mtxc = 8'($urandom);
    @(posedge clk);
    model_word(d, c, mtxd, mtxc);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; rxd = W_REM2; rxc = C_TWO;
    mtxd = {$urandom, $urandom}; mtxc = 8'($urandom);
    @(posedge clk);
    model_reset();
    #1;
  endtask

  task automatic gen_col(input int p, input int pref, output logic [31:0] d, output logic [3:0] c);
    int r;
    r = $urandom_range(99);
    if (r < p) begin
      d = ($urandom_range(99) < 80) == (pref == 1) ? 32'h0100009C : 32'h0200009C;
      c = 4'h1;
    end else begin
      d = 32'h0100009C; c = 4'h1;
      case ($urandom_range(6))
        0: c = 4'h3;
        1: d[15:8]  = 8'h01;
        2: d[31:24] = 8'h03;
        3: d[7:0]   = 8'hFB;
        4: d[23:16] = 8'h80;
        5: begin d = $urandom; c = 4'h0; end
        default: begin d = 32'h07070707; c = 4'hF; end
      endcase
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply_reset();
      vectors++;
      if (act !== {3'b000, W_IDLE, C_IDLE}) begin
        errors++;
        $display("FAIL reset_values cyc%0d: got %h want %h", i, act, {3'b000, W_IDLE, C_IDLE});
      end
    end
    drive_word(W_IDLE, C_IDLE);
    vectors++;
    if (link_ok !== 1'b1 || act !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", act, exp_vec());
    end
  endtask

  task automatic test_local_fault();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive_word(W_LOC0, C_ONE0);
      vectors++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL local_word%0d: got %h want %h", i, act, exp_vec());
      end
    end
    vectors++;
    if ({local_fault, remote_fault, link_ok, xgmii_txd, xgmii_txc} !== {3'b100, W_REM2, C_TWO}) begin
      errors++;
      $display("FAIL local_declared: got %h want %h", act, {3'b100, W_REM2, C_TWO});
    end
  endtask

  task automatic test_remote_fault();
    apply_reset();
    for (int i = 1; i <= 2; i++) begin
      drive_word(W_REM2, C_TWO);
      vectors++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL remote_word%0d: got %h want %h", i, act, exp_vec());
      end
    end
    vectors++;
    if (act !== {3'b010, W_IDLE, C_IDLE}) begin
      errors++;
      $display("FAIL remote_declared: got %h want %h", act, {3'b010, W_IDLE, C_IDLE});
    end
  endtask

  task automatic test_window_clear();
    for (int i = 0; i < WIN - 1; i++) drive_word(W_IDLE, C_IDLE);
    vectors++;
    if (remote_fault !== 1'b1 || act !== exp_vec()) begin
      errors++;
      $display("FAIL window_hold: got %h want %h", act, exp_vec());
    end
    drive_word(W_IDLE, C_IDLE);
    vectors++;
    if (act !== {3'b001, mtxd, mtxc}) begin
      errors++;
      $display("FAIL window_clear: got %h want %h", act, {3'b001, mtxd, mtxc});
    end
  endtask

  task automatic test_type_switch();
    apply_reset();
    for (int i = 1; i <= 7; i++) begin
      if (i <= 3) drive_word(W_LOC0, C_ONE0);
      else        drive_word(W_REM0, C_ONE0);
      vectors++;
      if (act !== exp_vec() || remote_fault !== (i == 7) || local_fault !== 1'b0) begin
        errors++;
        $display("FAIL switch_word%0d: got %h want %h", i, act, exp_vec());
      end
    end
    // Disagreeing columns count once, as the column-1 type.
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive_word({32'h0200009C, 32'h0100009C}, C_TWO);
      vectors++;
      if (act !== exp_vec() || remote_fault !== (i == 4)) begin
        errors++;
        $display("FAIL mixed_word%0d: got %h want %h", i, act, exp_vec());
      end
    end
  endtask

  task automatic test_reset_in_fault();
    apply_reset();
    drive_word(W_LOC2, C_TWO);
    drive_word(W_LOC2, C_TWO);
    apply_reset();
    vectors++;
    if (act !== {3'b000, W_IDLE, C_IDLE}) begin
      errors++;
      $display("FAIL reset_in_fault: got %h want %h", act, {3'b000, W_IDLE, C_IDLE});
    end
`ifdef LINK_FAULT_STATS_EN
    vectors++;
    if (fault_cnt !== 16'd0) begin
      errors++;
      $display("FAIL fault_cnt_reset: got %0d want 0", fault_cnt);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      drive_word((i % 2) ? W_LOC2 : W_REM2, C_TWO);
      drive_word((i % 2) ? W_LOC2 : W_REM2, C_TWO);
      vectors++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL reentry%0d: got %h want %h", i, act, exp_vec());
      end
    end
`ifdef LINK_FAULT_STATS_EN
    vectors++;
    if (fault_cnt !== 16'd3) begin
      errors++;
      $display("FAIL fault_cnt_three: got %0d want 3", fault_cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] d0, d1;
    logic [3:0]  c0, c1;
    int p, pref;
    apply_reset();
    for (int seg = 0; seg < 30; seg++) begin
      p    = (seg % 2) ? 70 : 4;
      pref = $urandom_range(1, 2);
      for (int w = 0; w < 100; w++) begin
        gen_col(p, pref, d0, c0);
        gen_col(p, pref, d1, c1);
        drive_word({d1, d0}, {c1, c0});
        vectors++;
        if (act !== exp_vec()) begin
          errors++;
          $display("FAIL random seg%0d w%0d: got %h want %h", seg, w, act, exp_vec());
        end
`ifdef LINK_FAULT_STATS_EN
        vectors++;
        if (fault_cnt !== 16'(m_cnt)) begin
          errors++;
          $display("FAIL random_cnt seg%0d w%0d: got %0d want %0d", seg, w, fault_cnt, m_cnt);
        end
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1; rxd = W_IDLE; rxc = C_IDLE; mtxd = '0; mtxc = '0;
    model_reset();
    test_reset();
    test_local_fault();
    test_remote_fault();
    test_window_clear();
    test_type_switch();
    test_reset_in_fault();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/xgmii_link_fault.md
XGMII_LINK_FAULT -- requirements
Module: xgmii_link_fault

Interface
REQ-001 Parameter C_SEQ_THRESH, default 4: number of same-type fault sequence columns that declares a fault.
REQ-002 Parameter C_WINDOW, default 64: number of consecutive 64-bit words without a fault sequence that cancels counting or clears a fault (64 words = 128 columns).
REQ-003 clk156  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 xgmii_rxd  in  64  registered RX XGMII data from the PHY interface stage.
REQ-006 xgmii_rxc  in  8  RX XGMII control, one bit per byte.
REQ-007 mac_txd  in  64  TX XGMII data from the MAC.
REQ-008 mac_txc  in  8  TX XGMII control from the MAC.
REQ-009 xgmii_txd  out  64  TX XGMII data toward the PHY interface stage.
REQ-010 xgmii_txc  out  8  TX XGMII control toward the PHY interface stage.
REQ-011 local_fault  out  1  local fault condition is active.
REQ-012 remote_fault  out  1  remote fault condition is active.
REQ-013 link_ok  out  1  high when no fault is active and the block is out of reset.
REQ-014 fault_cnt  out  16  fault-entry counter; present only with LINK_FAULT_STATS_EN.

Function
REQ-015 Column 0 is bytes [31:0] with rxc[3:0]; column 1 is bytes [63:32] with rxc[7:4].
REQ-016 A column is a sequence when all of the following hold: rxc nibble = 4'b0001; byte0 = 8'h9C; byte1 = 8'h00; byte2 = 8'h00; byte3 is 8'h01 (local) or 8'h02 (remote). Any other value is not a sequence.
REQ-017 Per word: n = number of sequence columns (0–2); the word type is taken from the lowest sequence column. If the two columns carry different types, the word is treated as type = column 1 with n = 1.
REQ-018 State machine has three states: INIT, COUNT and FAULT. It uses a 3-bit seq_cnt (saturating), a last_type register and a win_cnt word counter.
REQ-019 INIT, word with n > 0: last_type ← type; seq_cnt ← n; win_cnt ← 0; next state COUNT.
REQ-020 COUNT, word with the same type: seq_cnt ← seq_cnt + n; win_cnt ← 0. If the new seq_cnt ≥ C_SEQ_THRESH, go to FAULT and set the flag matching last_type.
REQ-021 COUNT, word with a different type: restart counting with last_type ← type, seq_cnt ← n, win_cnt ← 0.
REQ-022 COUNT, word with n = 0: win_cnt increments. When win_cnt = C_WINDOW-1, go to INIT and clear seq_cnt.
REQ-023 FAULT, word with the same type: win_cnt ← 0 and the flag is held.
REQ-024 FAULT, word with a different type: clear both flags and go to COUNT with the new type and seq_cnt ← n.
REQ-025 FAULT, word with n = 0: win_cnt increments. When win_cnt = C_WINDOW-1, go to INIT and clear both flags.
REQ-026 Flags are registered: a flag asserts on the clock edge after the word that reaches the threshold. local_fault and remote_fault are never high together.
REQ-027 link_ok is registered as !(next local_fault | next remote_fault) and is 0 during reset.
REQ-028 TX path has a one-cycle registered latency.
REQ-029 TX output when local_fault = 1: xgmii_txd = 64'h0200009C_0200009C, xgmii_txc = 8'h11 (remote fault sequence in both columns).
REQ-030 TX output when remote_fault = 1: xgmii_txd = 64'h07070707_07070707, xgmii_txc = 8'hFF (idle).
REQ-031 TX output otherwise: mac_txd/mac_txc pass through unchanged. The TX override uses the flag values registered on the same edge.

Reset
REQ-032 When reset is high at a clock edge, the following values load regardless of state or traffic in flight:
- state INIT, seq_cnt 0, win_cnt 0
- local_fault 0, remote_fault 0, link_ok 0
- xgmii_txd 64'h0707070707070707, xgmii_txc 8'hFF
- fault_cnt 0
REQ-033 On the first edge after reset deasserts: link_ok = 1, and normal processing resumes from INIT.

Configuration
REQ-034 With LINK_FAULT_STATS_EN defined: fault_cnt increments by 1 on each COUNT→FAULT transition and saturates at 16'hFFFF.
REQ-035 Without LINK_FAULT_STATS_EN: the fault_cnt port and its logic are absent, and all other behaviour is identical.

Verification
REQ-036 Scenario 1: drive 4 consecutive words, each with a local fault sequence in column 0 only and idle in column 1.
- Required: local_fault = 1 and link_ok = 0 one cycle after the 4th word.
- Required: xgmii_txd = 64'h0200009C0200009C with txc 8'h11 starting on the same cycle.
REQ-037 Scenario 2: drive 2 words, each with remote fault sequences in both columns.
- Required: remote_fault = 1 after the 2nd word.
- Required: TX outputs idle 64'h0707070707070707/8'hFF while mac_txd carries data.
REQ-038 Scenario 3: while in FAULT, drive 63 idle words.
- Required: the flag is still high.
- Then drive 1 more idle word. Required: flag = 0 and link_ok = 1 on the next edge, and TX passes through mac_txd.
REQ-039 Scenario 4: drive 3 local sequences, then 1 remote sequence, then 3 remote sequences.
- Required: no flag after the first 4 words.
- Required: remote_fault = 1 after the 7th word.
REQ-040 Scenario 5: assert reset for 1 cycle while in FAULT.
- Required: all outputs take their REQ-032 values on that edge.
- Required: with LINK_FAULT_STATS_EN, fault_cnt = 0; after 3 further fault entries, fault_cnt = 3.
